hls_deadlock_report_arbiter: RTL and testbench

- Collects the single-bit `block` outputs of up to NUM_MON per-instance HLS deadlock monitors.
- Filters each for persistence, then arbitrates the confirmed ones round-robin.
- Reports one offender at a time over a valid/ready channel with a cycle timestamp; keeps a sticky mask and raises an interrupt.
- Sits at dataflow top level, between the monitors and the debug/status register block.

---
 rtl/hls_deadlock_report_arbiter.sv | 149 ++++++++++++++
 tb/tb_hls_deadlock_report_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report_arbiter.sv
// Gathers per-instance HLS deadlock monitor flags, debounces them, and reports
// confirmed offenders one at a time (round-robin) with a timestamp and sticky mask.
module hls_deadlock_report_arbiter #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [CNT_W-1:0]   report_cycles,
  output logic [NUM_MON-1:0] sticky_mask,
  output logic               irq
);

  typedef enum logic {IDLE, REPORT} state_e;

  localparam logic [7:0] PERSIST_C = 8'(PERSIST);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q [NUM_MON];
  logic [7:0]         cnt_d [NUM_MON];
  logic [NUM_MON-1:0] confirmed_q, confirmed_d;
  logic [NUM_MON-1:0] sticky_q, sticky_d;
  logic [NUM_MON-1:0] pending, reachNow, hsOneHot;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]   reportIdx_q, reportIdx_d;
  logic [CNT_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]   reportCycles_q, reportCycles_d;
  logic               reportValid_q, reportValid_d;
  logic               irq_q;
  logic               handshake;
  logic               grantFound;
  logic [IDX_W-1:0]   grantIdx;

  // Cyclic index base+offset, wrapping at NUM_MON (which need not be a power of two).
  function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] base, input int offset);
    int j;
    j = int'(base) + offset;
    if (j >= NUM_MON) j = j - NUM_MON;
    return IDX_W'(j);
  endfunction

  assign handshake = (state_q == REPORT) && report_ready;
  assign hsOneHot  = NUM_MON'(1) << reportIdx_q;
  assign pending   = confirmed_q & ~sticky_q;
  assign ts_d      = (ts_q == {CNT_W{1'b1}}) ? ts_q : ts_q + CNT_W'(1);

  always_comb begin
    reachNow = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (clear) begin
        cnt_d[i] = 8'd0;
      end else if (enable && mon_block[i]) begin
        cnt_d[i] = (cnt_q[i] == PERSIST_C) ? cnt_q[i] : cnt_q[i] + 8'd1;
      end else begin
        cnt_d[i] = 8'd0;
      end
      reachNow[i] = (cnt_d[i] == PERSIST_C) && (cnt_q[i] != PERSIST_C);
    end

    confirmed_d = confirmed_q | reachNow;
    if (handshake) confirmed_d = confirmed_d & ~hsOneHot;
    if (clear) confirmed_d = '0;

    // A clear that coincides with a handshake still records the offender just reported.
    if (clear) begin
      sticky_d = handshake ? hsOneHot : '0;
    end else begin
      sticky_d = handshake ? (sticky_q | hsOneHot) : sticky_q;
    end
  end

  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_MON; k++) begin
      if (!grantFound && pending[rrIndex(rrPtr_q, k)]) begin
        grantFound = 1'b1;
        grantIdx   = rrIndex(rrPtr_q, k);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    reportValid_d  = reportValid_q;
    reportIdx_d    = reportIdx_q;
    reportCycles_d = reportCycles_q;
    rrPtr_d        = rrPtr_q;
    unique case (state_q)
      IDLE: begin
        if (enable && grantFound) begin
          reportIdx_d    = grantIdx;
          reportCycles_d = ts_q;
          reportValid_d  = 1'b1;
          state_d        = REPORT;
        end
      end
      REPORT: begin
        if (report_ready) begin
          reportValid_d = 1'b0;
          rrPtr_d       = (reportIdx_q == IDX_W'(NUM_MON - 1)) ? '0 : reportIdx_q + IDX_W'(1);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= 8'd0;
      confirmed_q    <= '0;
      sticky_q       <= '0;
      rrPtr_q        <= '0;
      reportIdx_q    <= '0;
      reportCycles_q <= '0;
      reportValid_q  <= 1'b0;
      ts_q           <= '0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      confirmed_q    <= confirmed_d;
      sticky_q       <= sticky_d;
      rrPtr_q        <= rrPtr_d;
      reportIdx_q    <= reportIdx_d;
      reportCycles_q <= reportCycles_d;
      reportValid_q  <= reportValid_d;
      ts_q           <= ts_d;
      irq_q          <= |sticky_q;
    end
  end

  assign report_valid  = reportValid_q;
  assign report_idx    = reportIdx_q;
  assign report_cycles = reportCycles_q;
  assign sticky_mask   = sticky_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Scoreboard bench for hls_deadlock_report_arbiter: directed scenarios push the
// expected reports, a negedge monitor checks every presented report against them.
module tb_hls_deadlock_report_arbiter;

  localparam int NUM_MON = 4;
  localparam int IDX_W   = 2;
  localparam int PERSIST = 4;
  localparam int CNT_W   = 16;

  logic               clock;
  logic               reset;
  logic               enable;
  logic [NUM_MON-1:0] monBlock;
  logic               clear;
  logic               reportValid;
  logic               reportReady;
  logic [IDX_W-1:0]   reportIdx;
  logic [CNT_W-1:0]   reportCycles;
  logic [NUM_MON-1:0] stickyMask;
  logic               irq;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cyc;
  } rep_t;

  rep_t       expQ[$];
  rep_t       front;
  int         checks = 0;
  int         errors = 0;
  logic [CNT_W-1:0] tsModel;
  logic [CNT_W-1:0] c;

  hls_deadlock_report_arbiter #(
    .NUM_MON(NUM_MON), .IDX_W(IDX_W), .PERSIST(PERSIST), .CNT_W(CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mon_block    (monBlock),
    .clear        (clear),
    .report_valid (reportValid),
    .report_ready (reportReady),
    .report_idx   (reportIdx),
    .report_cycles(reportCycles),
    .sticky_mask  (stickyMask),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference timestamp: counts edges since reset release, saturating.
  always @(posedge clock or posedge reset) begin
    if (reset) tsModel <= '0;
    else if (tsModel != {CNT_W{1'b1}}) tsModel <= tsModel + 1'b1;
  end

  // Every cycle a report is presented it must match the oldest expected report;
  // it is retired only when the consumer accepts it.
  always @(negedge clock) begin
    if (!reset && reportValid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_report idx=%0d cycles=%0d (none expected)", reportIdx, reportCycles);
      end else begin
        front = expQ[0];
        checks++;
        if (reportIdx !== front.idx || reportCycles !== front.cyc) begin
          errors++;
          $display("[TB] FAIL report_content got idx=%0d cycles=%0d, want idx=%0d cycles=%0d",
                   reportIdx, reportCycles, front.idx, front.cyc);
        end
        if (reportReady) void'(expQ.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [NUM_MON-1:0] blk,
                               input logic rdy, input logic clr);
    enable      = en;
    monBlock    = blk;
    reportReady = rdy;
    clear       = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [IDX_W-1:0] idx, input logic [CNT_W-1:0] cyc);
    rep_t r;
    r.idx = idx;
    r.cyc = cyc;
    expQ.push_back(r);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"},  32'(reportValid), 32'd0);
    checkOutput({tag, "_idx"},    32'(reportIdx), 32'd0);
    checkOutput({tag, "_cycles"}, 32'(reportCycles), 32'd0);
    checkOutput({tag, "_sticky"}, 32'(stickyMask), 32'd0);
    checkOutput({tag, "_irq"},    32'(irq), 32'd0);
  endtask

  // Asserts reset between edges, checks outputs clear before any edge, releases after the next edge.
  task automatic doReset(input string tag);
    #2;
    reset = 1'b1;
    expQ.delete();
    #1;
    checkAllZero(tag);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    #3;
    checkAllZero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Persistence pass on monitor 2
    c = tsModel;
    pushExp(2'd2, c + CNT_W'(PERSIST));
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
    tick(4);
    checkOutput("persist_no_early_valid", 32'(reportValid), 32'd0);
    tick(1);
    checkOutput("persist_valid_edge5", 32'(reportValid), 32'd1);
    tick(1);
    monBlock = 4'b0000;
    checkOutput("persist_valid_dropped", 32'(reportValid), 32'd0);
    checkOutput("persist_sticky", 32'(stickyMask), 32'h4);
    checkOutput("persist_irq_lag", 32'(irq), 32'd0);
    tick(1);
    checkOutput("persist_irq", 32'(irq), 32'd1);

    // Glitch reject on monitor 1: 3 high, 1 low, 3 high
    for (int k = 0; k < 10; k++) begin
      monBlock = (k < 3 || (k >= 4 && k < 7)) ? 4'b0010 : 4'b0000;
      tick(1);
      checkOutput("glitch_no_valid", 32'(reportValid), 32'd0);
    end
    checkOutput("glitch_sticky", 32'(stickyMask), 32'h4);

    // Round-robin with backpressure from a fresh pointer
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    doReset("rr_reset");
    c = tsModel;
    pushExp(2'd0, c + 16'd4);
    pushExp(2'd1, c + 16'd11);
    pushExp(2'd3, c + 16'd13);
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0);
    tick(5);
    checkOutput("rr_first_valid", 32'(reportValid), 32'd1);
    tick(5);
    checkOutput("rr_stall_valid", 32'(reportValid), 32'd1);
    reportReady = 1'b1;
    tick(5);
    checkOutput("rr_sticky", 32'(stickyMask), 32'hB);
    checkOutput("rr_idle", 32'(reportValid), 32'd0);
    monBlock = 4'b0000;

    // Clear colliding with the handshake of index 3
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checkOutput("clear_sticky", 32'(stickyMask), 32'd0);
    tick(1);
    checkOutput("clear_irq", 32'(irq), 32'd0);
    c = tsModel;
    pushExp(2'd0, c + 16'd4);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
    tick(6);
    checkOutput("coll_pre_sticky", 32'(stickyMask), 32'h1);
    c = tsModel;
    pushExp(2'd3, c + 16'd4);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    tick(6);
    checkOutput("coll_stalled_valid", 32'(reportValid), 32'd1);
    reportReady = 1'b1;
    clear       = 1'b1;
    tick(1);
    clear    = 1'b0;
    monBlock = 4'b0000;
    checkOutput("coll_sticky", 32'(stickyMask), 32'h8);
    checkOutput("coll_valid_done", 32'(reportValid), 32'd0);
    tick(1);
    checkOutput("coll_irq", 32'(irq), 32'd1);

    // Async reset while a report is outstanding, then timestamp restart
    c = tsModel;
    pushExp(2'd2, c + 16'd4);
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    tick(5);
    checkOutput("async_pre_valid", 32'(reportValid), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    doReset("async");
    pushExp(2'd3, 16'd4);
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
    tick(5);
    checkOutput("restart_cycles", 32'(reportCycles), 32'd4);
    tick(1);
    monBlock = 4'b0000;

    // Enable gating
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checkOutput("gated_no_valid", 32'(reportValid), 32'd0);
    end
    c = tsModel;
    pushExp(2'd0, c + 16'd4);
    pushExp(2'd1, c + 16'd6);
    pushExp(2'd2, c + 16'd8);
    pushExp(2'd3, c + 16'd10);
    enable = 1'b1;
    tick(4);
    checkOutput("enable_no_early_valid", 32'(reportValid), 32'd0);
    tick(1);
    checkOutput("enable_valid_edge5", 32'(reportValid), 32'd1);
    checkOutput("enable_first_idx", 32'(reportIdx), 32'd0);
    tick(7);
    checkOutput("enable_sticky", 32'(stickyMask), 32'hF);
    monBlock = 4'b0000;
    tick(2);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
